// File: rtl/pick_tx_if.sv
// Pixel-source handshake and link-side bus of the transmit framer.
// The source/bench side uses master; the framer uses slave.
interface pick_tx_if #(
    parameter int unsigned pixelWidth = 16
);
    logic                  PIXEL_VALID_IN;
    logic [pixelWidth-1:0] PIXEL_DATA_IN;
    logic                  PIXEL_READY;
    logic [pixelWidth-1:0] DOUT;
    logic                  FRAME_ACTIVE;
    logic [pixelWidth-1:0] FRAME_CNT;

    modport master (
        output PIXEL_VALID_IN, PIXEL_DATA_IN,
        input  PIXEL_READY, DOUT, FRAME_ACTIVE, FRAME_CNT
    );

    modport slave (
        input  PIXEL_VALID_IN, PIXEL_DATA_IN,
        output PIXEL_READY, DOUT, FRAME_ACTIVE, FRAME_CNT
    );
endinterface

// File: rtl/pick_tx.sv
// Transmit-side framer: buffers pixels in a FIFO and emits FFFF,FFFF,AAAA,ctrl,pixels
// frames on a continuous one-word-per-cycle bus, idle word between frames.
module pick_tx #(
    parameter int unsigned           pixelWidth = 16,
    parameter int unsigned           numPixel   = 16,
    parameter logic [pixelWidth-1:0] IDLE_WORD  = 16'h0000
) (
    input logic       CLK,
    input logic       nRST,
    pick_tx_if.slave  bus
);
    localparam int unsigned DEPTH = 2 * numPixel;
    localparam int unsigned PW    = $clog2(DEPTH);
    localparam int unsigned CW    = $clog2(DEPTH + 1);
    localparam int unsigned IW    = $clog2(numPixel);

    typedef logic [pixelWidth-1:0] word_t;
    localparam word_t HDR_WORD  = 16'hFFFF;
    localparam word_t SYNC_WORD = 16'hAAAA;

    // The state names the word currently held in DOUT, so the word for the
    // next state is loaded on the same edge as the transition.
    typedef enum logic [2:0] {IDLE, HDR0, HDR1, SYNC, CNTL, PIX} state_e;

    state_e          state_q, state_d;
    word_t           dout_q, dout_d;
    logic            active_q, active_d;
    word_t           fcnt_q, fcnt_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    word_t           mem_q [DEPTH];

    logic ready, push, pop, frame_ready;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign ready       = count_q < CW'(DEPTH);
    assign push        = bus.PIXEL_VALID_IN && ready;
    // Decided on registered occupancy only; a push landing this edge is not counted.
    assign frame_ready = count_q >= CW'(numPixel);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_d = state_q;
        dout_d  = dout_q;
        fcnt_d  = fcnt_q;
        idx_d   = idx_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                dout_d = IDLE_WORD;
                if (frame_ready) begin
                    state_d = HDR0;
                    dout_d  = HDR_WORD;
                end
            end
            HDR0: begin
                state_d = HDR1;
                dout_d  = HDR_WORD;
            end
            HDR1: begin
                state_d = SYNC;
                dout_d  = SYNC_WORD;
            end
            SYNC: begin
                state_d = CNTL;
                dout_d  = fcnt_q;
            end
            CNTL: begin
                state_d = PIX;
                dout_d  = mem_q[rd_ptr_q];
                pop     = 1'b1;
                idx_d   = '0;
            end
            PIX: begin
                if (idx_q == IW'(numPixel - 1)) begin
                    // Last pixel is on the bus: chain straight into the next frame if one is buffered.
                    state_d = frame_ready ? HDR0 : IDLE;
                    dout_d  = frame_ready ? HDR_WORD : IDLE_WORD;
                end else begin
                    dout_d = mem_q[rd_ptr_q];
                    pop    = 1'b1;
                    idx_d  = idx_q + IW'(1);
                    if (idx_q == IW'(numPixel - 2)) fcnt_d = fcnt_q + word_t'(1);
                end
            end
            default: begin
                state_d = IDLE;
                dout_d  = IDLE_WORD;
            end
        endcase
        active_d = (state_d != IDLE);
    end

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            dout_q   <= IDLE_WORD;
            active_q <= 1'b0;
            fcnt_q   <= '0;
            idx_q    <= '0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            dout_q   <= dout_d;
            active_q <= active_d;
            fcnt_q   <= fcnt_d;
            idx_q    <= idx_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is not reset; occupancy and pointers alone define which entries are valid.
    always_ff @(posedge CLK) begin
        if (push) mem_q[wr_ptr_q] <= bus.PIXEL_DATA_IN;
    end

    assign bus.PIXEL_READY  = ready;
    assign bus.DOUT         = dout_q;
    assign bus.FRAME_ACTIVE = active_q;
    assign bus.FRAME_CNT    = fcnt_q;
endmodule

// File: tb/tb_pick_tx.sv
// Bench for pick_tx: directed scenarios plus random traffic, compared every cycle
// against a frame-schedule model built from queues.
module tb_pick_tx;
    localparam int    NP        = 16;
    localparam int    PWID      = 16;
    localparam logic [15:0] IDLE_W = 16'h0000;
    localparam logic [15:0] MARKER = 16'hDEAD;

    logic CLK = 1'b0;
    logic nRST = 1'b1;

    pick_tx_if #(.pixelWidth(PWID)) bus ();

    pick_tx #(.pixelWidth(PWID), .numPixel(NP), .IDLE_WORD(IDLE_W)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    int n_asserts = 0;
    int n_fail    = 0;
    int act_cnt   = 0;
    bit ready_low_seen = 0;
    bit marker_seen    = 0;

    // Model: buffered pixels plus a schedule of the words still owed to the bus.
    typedef struct {
        bit          is_pix;
        bit          last;
        logic [15:0] w;
    } item_t;

    logic [15:0] mbuf[$];
    item_t       sched[$];
    logic [15:0] m_dout;
    logic        m_active;
    logic [15:0] m_fcnt;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit m_ready();
        return mbuf.size() < 2 * NP;
    endfunction

    task automatic model_reset();
        mbuf.delete();
        sched.delete();
        m_dout   = IDLE_W;
        m_active = 1'b0;
        m_fcnt   = '0;
    endtask

    task automatic model_step(input logic v, input logic [15:0] d);
        item_t it;
        bit    push;
        push = v && m_ready();
        if (sched.size() == 0 && mbuf.size() >= NP) begin
            sched.push_back('{is_pix: 1'b0, last: 1'b0, w: 16'hFFFF});
            sched.push_back('{is_pix: 1'b0, last: 1'b0, w: 16'hFFFF});
            sched.push_back('{is_pix: 1'b0, last: 1'b0, w: 16'hAAAA});
            sched.push_back('{is_pix: 1'b0, last: 1'b0, w: m_fcnt});
            for (int i = 0; i < NP; i++)
                sched.push_back('{is_pix: 1'b1, last: (i == NP - 1), w: 16'h0});
        end
        if (sched.size() > 0) begin
            it       = sched.pop_front();
            m_active = 1'b1;
            if (it.is_pix) begin
                m_dout = mbuf.pop_front();
                if (it.last) m_fcnt = m_fcnt + 16'd1;
            end else begin
                m_dout = it.w;
            end
        end else begin
            m_dout   = IDLE_W;
            m_active = 1'b0;
        end
        if (push) mbuf.push_back(d);
    endtask

    // One clock: drive inputs, check READY, clock, check registered outputs.
    task automatic cycle(input logic v, input logic [15:0] d);
        bus.PIXEL_VALID_IN = v;
        bus.PIXEL_DATA_IN  = d;
        check("ready", {15'b0, bus.PIXEL_READY}, {15'b0, m_ready()});
        @(posedge CLK);
        model_step(v, d);
        #1;
        check("dout", bus.DOUT, m_dout);
        check("frame_active", {15'b0, bus.FRAME_ACTIVE}, {15'b0, m_active});
        check("frame_cnt", bus.FRAME_CNT, m_fcnt);
        if (bus.FRAME_ACTIVE === 1'b1) act_cnt++;
        if (bus.DOUT === MARKER) marker_seen = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] seq;
        logic [15:0] pay [NP];

        bus.PIXEL_VALID_IN = 1'b0;
        bus.PIXEL_DATA_IN  = '0;
        model_reset();

        // Reset takes effect before any clock edge.
        #2 nRST = 1'b0;
        #1;
        check("rst_dout", bus.DOUT, IDLE_W);
        check("rst_active", {15'b0, bus.FRAME_ACTIVE}, 16'h0);
        check("rst_fcnt", bus.FRAME_CNT, 16'h0);
        check("rst_ready", {15'b0, bus.PIXEL_READY}, 16'h1);
        repeat (2) @(negedge CLK);
        nRST = 1'b1;

        // Basic frame from 16 consecutive pushes.
        act_cnt = 0;
        for (int i = 1; i <= NP; i++) cycle(1'b1, 16'(i));
        cycle(1'b0, '0);
        check("first_hdr_latency", bus.DOUT, 16'hFFFF);
        repeat (24) cycle(1'b0, '0);
        check("frame1_active_len", 16'(act_cnt), 16'd20);
        check("frame1_cnt", bus.FRAME_CNT, 16'd1);

        // 15 pixels are not enough; the 16th starts the frame one edge later.
        for (int i = 0; i < NP - 1; i++) cycle(1'b1, 16'h0100 + 16'(i));
        repeat (10) cycle(1'b0, '0);
        check("short_idle_dout", bus.DOUT, IDLE_W);
        check("short_idle_active", {15'b0, bus.FRAME_ACTIVE}, 16'h0);
        cycle(1'b1, 16'h010F);
        check("16th_push_still_idle", bus.DOUT, IDLE_W);
        cycle(1'b0, '0);
        check("16th_push_hdr", bus.DOUT, 16'hFFFF);
        repeat (25) cycle(1'b0, '0);

        // Header-lookalike payload passes through untouched.
        act_cnt = 0;
        for (int i = 0; i < NP; i++) pay[i] = 16'h0200 + 16'(i);
        pay[3] = 16'hFFFF;
        pay[4] = 16'hFFFF;
        pay[5] = 16'hAAAA;
        for (int i = 0; i < NP; i++) cycle(1'b1, pay[i]);
        repeat (25) cycle(1'b0, '0);
        check("lookalike_active_len", 16'(act_cnt), 16'd20);

        // Asynchronous reset while pixel 7 is on the bus.
        for (int i = 0; i < NP; i++) cycle(1'b1, 16'h2000 + 16'(i));
        repeat (12) cycle(1'b0, '0);
        check("pix7_before_reset", bus.DOUT, 16'h2007);
        #2 nRST = 1'b0;
        #1;
        check("midrst_dout", bus.DOUT, IDLE_W);
        check("midrst_fcnt", bus.FRAME_CNT, 16'h0);
        check("midrst_active", {15'b0, bus.FRAME_ACTIVE}, 16'h0);
        model_reset();
        @(negedge CLK);
        nRST = 1'b1;
        for (int i = 0; i < NP; i++) cycle(1'b1, 16'h3000 + 16'(i));
        repeat (4) cycle(1'b0, '0);
        check("fresh_ctrl_word", bus.DOUT, 16'h0000);
        repeat (20) cycle(1'b0, '0);

        // Continuous source; a marker is offered whenever the buffer is full.
        seq = 16'h1000;
        for (int i = 0; i < 200; i++) begin
            if (m_ready()) begin
                cycle(1'b1, seq);
                seq = seq + 16'd1;
            end else begin
                ready_low_seen = 1'b1;
                cycle(1'b1, MARKER);
            end
        end
        repeat (60) cycle(1'b0, '0);
        check("ready_dropped", {15'b0, ready_low_seen}, 16'h1);
        check("marker_never_sent", {15'b0, marker_seen}, 16'h0);

        // Random traffic.
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 3) != 0, 16'($urandom));
        repeat (60) cycle(1'b0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule

// File: doc/pick_tx.md
# pick_tx

Transmit-side framer for the pixel-stream link. Accepts pixels through a valid/ready handshake, buffers them, and emits on a continuous one-word-per-cycle bus a frame of header 16'hFFFF, 16'hFFFF, 16'hAAAA, a control word, then exactly `numPixel` pixel words with no gaps. Between frames the bus carries an idle word. Its output feeds the link's receive-side deframer directly.

## Interface
- `pixelWidth`, 16: width of pixel and bus words; fixed at 16 for this link (header constants are 16-bit).
- `numPixel`, 16: pixels per frame; must be ≥ 2.
- `IDLE_WORD`, 16'h0000: word driven when no frame is in progress; must not be 16'hFFFF.
- `CLK` in 1: single clock, all logic on rising edge.
- `nRST` in 1: asynchronous, active-low reset.
- `PIXEL_VALID_IN` in 1: source offers a pixel.
- `PIXEL_DATA_IN` in pixelWidth: offered pixel.
- `PIXEL_READY` out 1: buffer can accept; a transfer occurs on an edge where VALID_IN && READY.
- `DOUT` out pixelWidth: registered link word.
- `FRAME_ACTIVE` out 1: registered; high while DOUT carries any header, control, or pixel word.
- `FRAME_CNT` out pixelWidth: number of frames completed, wraps modulo 2^pixelWidth.

## Operation
- Buffer: FIFO, depth 2*numPixel, registered occupancy `count` (0..2*numPixel).
- PIXEL_READY = (count < 2*numPixel), combinational from registered count only; independent of PIXEL_VALID_IN.
- Push when VALID_IN && READY. A push while !READY is ignored; the pixel is not stored and the source must hold it.
- FSM states: IDLE, HDR0, HDR1, SYNC, CNTL, PIX.
- IDLE: DOUT <= IDLE_WORD. If the registered count ≥ numPixel, go to HDR0. An arriving push this cycle does not count toward the decision.
- HDR0: DOUT <= 16'hFFFF. HDR1: DOUT <= 16'hFFFF. SYNC: DOUT <= 16'hAAAA.
- CNTL: DOUT <= FRAME_CNT, the value at the frame's start. Load the pixel index to 0.
- PIX: DOUT <= FIFO head, pop one, increment the index.
  - On the edge that emits pixel numPixel-1, FRAME_CNT increments.
  - Next state is HDR0 if count after this pop ≥ numPixel (back-to-back frame, zero idle words). Otherwise it is IDLE.
- Pixels leave in arrival order; pixel values are never inspected (16'hFFFF payload allowed).
- Simultaneous push and pop in one cycle: count unchanged, both take effect. Pop never underflows, because a frame only starts with ≥ numPixel stored and only numPixel are popped.
- FRAME_ACTIVE is high in the cycles DOUT holds HDR0..last pixel, otherwise low.

## Timing
- Reset (nRST low, asynchronous) values:
  - DOUT = IDLE_WORD, FRAME_ACTIVE = 0, FRAME_CNT = 0.
  - count = 0, FSM = IDLE, FIFO pointers 0.
  - PIXEL_READY = 1 once reset is applied.
- Reset mid-frame aborts immediately. The bus returns to IDLE_WORD; buffered pixels and the partial frame are discarded.
- A frame occupies exactly numPixel+4 consecutive DOUT cycles.
- Latency: if the numPixel-th pixel is pushed on edge N with an empty start and FSM in IDLE, DOUT = 16'hFFFF after edge N+1. The first pixel appears after edge N+5, and the last after edge N+4+numPixel.
- Throughput: a continuous source at one pixel/cycle exceeds link rate (numPixel per numPixel+4). READY drops when the FIFO fills; no pixel is lost or duplicated.

## Test plan
- Reset, then push pixels 16'h0001..16'h0010 on 16 consecutive edges -> DOUT sequence: IDLE_WORD, FFFF, FFFF, AAAA, 0000, 0001..0010, IDLE_WORD. FRAME_ACTIVE is high for exactly 20 cycles. FRAME_CNT = 1 after the last pixel.
- Push 15 pixels then stop -> DOUT stays IDLE_WORD, FRAME_ACTIVE 0. A 16th push starts the frame 1 edge later.
- Continuous VALID_IN for 200 cycles with incrementing data -> frames back-to-back with zero idle words. READY deasserts at count = 32. The control words are 0, 1, 2, …. Payload is the exact incrementing sequence with no loss or duplication.
- Payload containing 16'hFFFF, 16'hFFFF, 16'hAAAA in pixels 3..5 -> emitted unchanged in place; frame length still 20.
- Assert nRST low during pixel 7 of a frame -> DOUT = IDLE_WORD and FRAME_CNT = 0 asynchronously. After release, 16 new pushes produce a complete fresh frame with control word 0.
- Drive VALID_IN while READY = 0 with a distinct marker value -> the marker never appears on DOUT unless re-offered once READY = 1.
